// File: rtl/line_buffer_n.sv
// line_buffer_n: N-line video line buffer presenting a vertical pixel column per accepted pixel.
// Optional feature macro: LINE_BUFFER_EDGE_REPLICATE_EN (top-border replication, valid from row 0).
module line_buffer_n #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PIC_WIDTH = 250,
    parameter int unsigned NUM_LINES = 3,
    parameter int unsigned CNT_W     = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sof,
    input  logic                          valid_in,
    input  logic [DATA_W-1:0]             din,
    output logic [NUM_LINES*DATA_W-1:0]   taps,
    output logic                          valid_out,
    output logic [CNT_W-1:0]              col_out,
    output logic [CNT_W-1:0]              row_out,
    output logic                          line_end
);

    localparam int unsigned ADDR_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int unsigned FILL_W = $clog2(NUM_LINES);
    localparam int unsigned NMEM   = NUM_LINES - 1;

    localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0]  ROW_MAX  = '1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_LINES - 1);

    logic [CNT_W-1:0]  col, col_nxt;
    logic [CNT_W-1:0]  row, row_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;

    // sof forces this pixel to be column 0 of row 0 of an empty buffer
    logic [CNT_W-1:0]  eff_col;
    logic [CNT_W-1:0]  eff_row;
    logic [FILL_W-1:0] eff_fill;
    logic [ADDR_W-1:0] addr;

    logic [DATA_W-1:0]           col_data [NUM_LINES];
    logic [NUM_LINES*DATA_W-1:0] taps_nxt;
    logic                        valid_nxt;

    assign eff_col  = sof ? '0 : col;
    assign eff_row  = sof ? '0 : row;
    assign eff_fill = sof ? '0 : fill;
    assign addr     = eff_col[ADDR_W-1:0];

    // slice 0 is the incoming pixel; slice k comes from line memory k-1
    assign col_data[0] = din;

    genvar m;
    generate
        for (m = 0; m < NMEM; m++) begin : g_mem
            logic [DATA_W-1:0] mem [PIC_WIDTH];

            // read-first: the column read sees the value before this cycle's shift write
            assign col_data[m+1] = mem[addr];

            // vertical shift at the current column: memory m takes slice m
            always_ff @(posedge clk) begin
                if (valid_in) begin
                    mem[addr] <= col_data[m];
                end
            end
        end
    endgenerate

    // next-state for column/row/fill tracking
    always_comb begin
        col_nxt  = col;
        row_nxt  = row;
        fill_nxt = fill;
        if (valid_in) begin
            if (eff_col == COL_LAST) begin
                col_nxt  = '0;
                row_nxt  = (eff_row == ROW_MAX) ? eff_row : eff_row + CNT_W'(1);
                fill_nxt = (eff_fill == FILL_MAX) ? eff_fill : eff_fill + FILL_W'(1);
            end else begin
                col_nxt  = eff_col + CNT_W'(1);
                row_nxt  = eff_row;
                fill_nxt = eff_fill;
            end
        end else if (sof) begin
            col_nxt  = '0;
            row_nxt  = '0;
            fill_nxt = '0;
        end
    end

    // tap assembly: rows not yet written in this frame are never exposed
    always_comb begin
        taps_nxt = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (FILL_W'(k) <= eff_fill) begin
                taps_nxt[k*DATA_W +: DATA_W] = col_data[k];
            end else begin
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
                taps_nxt[k*DATA_W +: DATA_W] = col_data[eff_fill];
`else
                taps_nxt[k*DATA_W +: DATA_W] = '0;
`endif
            end
        end
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
        valid_nxt = 1'b1;
`else
        valid_nxt = (eff_fill == FILL_MAX);
`endif
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            fill <= '0;
        end else begin
            col  <= col_nxt;
            row  <= row_nxt;
            fill <= fill_nxt;
        end
    end

    // output registers: update on accept, hold otherwise with valid_out dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps      <= '0;
            valid_out <= 1'b0;
            col_out   <= '0;
            row_out   <= '0;
            line_end  <= 1'b0;
        end else if (valid_in) begin
            taps      <= taps_nxt;
            valid_out <= valid_nxt;
            col_out   <= eff_col;
            row_out   <= eff_row;
            line_end  <= (eff_col == COL_LAST);
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_n.sv
// Testbench for line_buffer_n: randomized streams against a frame-store reference model.
module tb_line_buffer_n;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 4;
    localparam int unsigned NL = 3;
    localparam int unsigned CW = 11;
    localparam int          ROW_SAT = (1 << CW) - 1;

`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sof = 1'b0;
    logic             valid_in = 1'b0;
    logic [DW-1:0]    din = '0;
    logic [NL*DW-1:0] taps;
    logic             valid_out;
    logic [CW-1:0]    col_out;
    logic [CW-1:0]    row_out;
    logic             line_end;

    int checks = 0;
    int errors = 0;

    line_buffer_n #(.DATA_W(DW), .PIC_WIDTH(PW), .NUM_LINES(NL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in), .din(din),
        .taps(taps), .valid_out(valid_out), .col_out(col_out), .row_out(row_out),
        .line_end(line_end)
    );

    always #5 clk = ~clk;

    // reference model: pixels of the current frame kept by (row, col)
    int               m_col, m_row, m_fill;
    logic [DW-1:0]    pix [int];
    logic [NL*DW-1:0] e_taps;
    logic             e_valid;
    logic [CW-1:0]    e_col, e_row;
    logic             e_le;

    task automatic model_reset();
        m_col = 0; m_row = 0; m_fill = 0;
        pix.delete();
        e_taps = '0; e_valid = 1'b0; e_col = '0; e_row = '0; e_le = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [DW-1:0] d);
        int top;
        if (s) begin
            m_col = 0; m_row = 0; m_fill = 0;
            pix.delete();
        end
        if (v) begin
            pix[m_row*PW + m_col] = d;
            top = m_row - m_fill;
            for (int k = 0; k < NL; k++) begin
                if (k <= m_fill)
                    e_taps[k*DW +: DW] = pix[(m_row - k)*PW + m_col];
                else
                    e_taps[k*DW +: DW] = REP ? pix[top*PW + m_col] : '0;
            end
            e_valid = REP || (m_fill == NL - 1);
            e_col   = CW'(m_col);
            e_row   = (m_row > ROW_SAT) ? CW'(ROW_SAT) : CW'(m_row);
            e_le    = (m_col == PW - 1);
            m_col++;
            if (m_col == PW) begin
                m_col = 0;
                m_row++;
                if (m_fill < NL - 1) m_fill++;
            end
        end else begin
            e_valid = 1'b0;
        end
    endtask

    // one clock: drive inputs, let the edge happen, advance the model
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        sof = s; valid_in = v; din = d;
        @(posedge clk);
        #1;
        model_step(s, v, d);
        sof = 1'b0; valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({taps, valid_out, col_out, row_out, line_end} !== '0) begin
            errors++;
            $display("FAIL reset_state: got taps=%h v=%b col=%0d row=%0d le=%b, want all zero",
                     taps, valid_out, col_out, row_out, line_end);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < PW; c++) begin
                step(r == 0 && c == 0, 1'b1, DW'(16*r + c));
                checks++;
                if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                    errors++;
                    $display("FAIL stream r%0d c%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                             r, c, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
                end
`ifndef LINE_BUFFER_EDGE_REPLICATE_EN
                if (r == 2 && c == 0) begin
                    checks++;
                    if ({taps, valid_out} !== {24'h001020, 1'b1}) begin
                        errors++;
                        $display("FAIL first_valid: got taps=%h v=%b, want taps=001020 v=1", taps, valid_out);
                    end
                end
                if (r == 2 && c == 3) begin
                    checks++;
                    if ({taps, line_end} !== {24'h031323, 1'b1}) begin
                        errors++;
                        $display("FAIL line_end: got taps=%h le=%b, want taps=031323 le=1", taps, line_end);
                    end
                end
`else
                if (r == 0 && c == 1) begin
                    checks++;
                    if ({taps, valid_out} !== {24'h010101, 1'b1}) begin
                        errors++;
                        $display("FAIL replicate_r0: got taps=%h v=%b, want taps=010101 v=1", taps, valid_out);
                    end
                end
                if (r == 1 && c == 1) begin
                    checks++;
                    if ({taps, valid_out} !== {24'h010111, 1'b1}) begin
                        errors++;
                        $display("FAIL replicate_r1: got taps=%h v=%b, want taps=010111 v=1", taps, valid_out);
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_gaps();
        int n = 0;
        while (n < 3*PW) begin
            if ($urandom_range(1) == 1) begin
                step(n == 0, 1'b1, DW'(16*(n / PW) + (n % PW)));
                n++;
            end else begin
                step(1'b0, 1'b0, DW'($urandom));
            end
            checks++;
            if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                errors++;
                $display("FAIL gaps n%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                         n, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
            end
        end
    endtask

    task automatic test_sof_mid();
        // frame 1: three full rows; frame 2 interrupted at row 1; frame 3 with gaps
        for (int i = 0; i < 3*PW + 6 + 4*PW; i++) begin
            logic s;
            logic v;
            s = (i == 0) || (i == 3*PW) || (i == 3*PW + 6);
            v = s || (i < 3*PW + 6) || ($urandom_range(3) != 0);
            step(s, v, DW'($urandom));
            checks++;
            if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                errors++;
                $display("FAIL sof_mid i%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                         i, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2*PW + 2; i++) step(i == 0, 1'b1, DW'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({taps, valid_out, col_out, row_out, line_end} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got taps=%h v=%b col=%0d row=%0d le=%b, want all zero",
                     taps, valid_out, col_out, row_out, line_end);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3*PW; i++) begin
            step(1'b0, 1'b1, DW'($urandom));
            checks++;
            if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                errors++;
                $display("FAIL after_reset i%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                         i, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
            end
        end
    endtask

    task automatic test_sof_aa();
        for (int i = 0; i < 5; i++) step(i == 0, 1'b1, DW'($urandom));
        step(1'b1, 1'b1, 8'hAA);
        checks++;
`ifndef LINE_BUFFER_EDGE_REPLICATE_EN
        if ({taps, valid_out, col_out, row_out} !== {24'h0000AA, 1'b0, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL sof_aa: got taps=%h v=%b col=%0d row=%0d, want taps=0000aa v=0 col=0 row=0",
                     taps, valid_out, col_out, row_out);
        end
`else
        if ({taps, valid_out, col_out, row_out} !== {24'hAAAAAA, 1'b1, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL sof_aa: got taps=%h v=%b col=%0d row=%0d, want taps=aaaaaa v=1 col=0 row=0",
                     taps, valid_out, col_out, row_out);
        end
`endif
        // sof alone clears the position; next pixel lands at column 0
        step(1'b0, 1'b1, DW'($urandom));
        step(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, DW'($urandom));
            checks++;
            if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                errors++;
                $display("FAIL sof_idle i%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                         i, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
            end
        end
    endtask

    task automatic test_row_sat();
        for (int i = 0; i < (ROW_SAT + 3)*PW; i++) begin
            step(i == 0, 1'b1, DW'($urandom));
            checks++;
            if ({taps, valid_out, col_out, row_out, line_end} !== {e_taps, e_valid, e_col, e_row, e_le}) begin
                errors++;
                $display("FAIL row_sat i%0d: got taps=%h v=%b col=%0d row=%0d le=%b, want taps=%h v=%b col=%0d row=%0d le=%b",
                         i, taps, valid_out, col_out, row_out, line_end, e_taps, e_valid, e_col, e_row, e_le);
            end
        end
        checks++;
        if (row_out !== CW'(ROW_SAT)) begin
            errors++;
            $display("FAIL row_hold: got row=%0d, want row=%0d", row_out, ROW_SAT);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_gaps();
        test_sof_mid();
        test_reset_mid();
        test_sof_aa();
        test_row_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
